// File: rtl/vector_group_register_file_pkg.sv
// Shared encodings for the grouped vector register file: element widths,
// status codes, write-back FSM states and the agnostic fill value.
package vector_group_register_file_pkg;

    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    localparam logic [1:0] RF_NOP      = 2'd0;
    localparam logic [1:0] RF_BUSY     = 2'd1;
    localparam logic [1:0] RF_FINISHED = 2'd2;
    localparam logic [1:0] RF_ERROR    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } rf_state_e;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    function automatic logic sew_legal(input logic [2:0] sew);
        return sew <= EIGHT_BYTE;
    endfunction

    // A group base must sit on a 2^lmul register boundary.
    function automatic logic rd_aligned(input logic [4:0] rd, input logic [1:0] lmul);
        logic [4:0] low_bits;
        low_bits = (5'd1 << lmul) - 5'd1;
        return (rd & low_bits) == 5'd0;
    endfunction

endpackage

// File: rtl/vrf_element_merge.sv
// Combinational merge of one group member: per-byte write enable and fill mux
// implementing the vstart / body / mask / tail rules.
module vrf_element_merge
    import vector_group_register_file_pkg::*;
#(
    parameter int VLEN     = 256,
    parameter int DATA_LEN = 32
) (
    input  logic [VLEN-1:0]     old_data,
    input  logic [VLEN-1:0]     beat_data,
    input  logic [VLEN-1:0]     mask,
    input  logic [DATA_LEN-1:0] vstart,
    input  logic [DATA_LEN-1:0] vl,
    input  logic [2:0]          beat,
    input  logic [1:0]          sew,
    input  logic                vm,
    input  logic                vta,
    input  logic                vma,
    output logic [VLEN-1:0]     merged
);

    localparam int NBYTES = VLEN / 8;
    localparam int LB     = $clog2(NBYTES);
    localparam int BW     = LB + 3;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            localparam logic [LB-1:0] BYTE_IDX = LB'(gi);
            logic [BW-1:0]       elem;
            logic [DATA_LEN-1:0] elem_ext;
            logic                is_head;
            logic                in_body;
            logic                active;
            logic                byte_wen;
            logic [7:0]          byte_val;
            logic [7:0]          out_byte;

            // Elements of a group are contiguous, so the element index is just
            // the group-wide byte index scaled down by the element width.
            always_comb begin
                elem     = {beat, BYTE_IDX} >> sew;
                elem_ext = DATA_LEN'(elem);
                is_head  = elem_ext < vstart;
                in_body  = !is_head && (elem_ext < vl);
                active   = vm || mask[elem];
                byte_wen = !is_head && (in_body ? (active || vma) : vta);
                byte_val = (in_body && active) ? beat_data[gi*8 +: 8] : FILL_BYTE;
                out_byte = byte_wen ? byte_val : old_data[gi*8 +: 8];
            end

            assign merged[gi*8 +: 8] = out_byte;
        end
    endgenerate

endmodule

// File: rtl/vector_group_register_file.sv
// 32 x VLEN vector register file with three registered-index read ports, a v0
// mask port and an FSM that writes an LMUL register group one member per cycle.
module vector_group_register_file
    import vector_group_register_file_pkg::*;
#(
    parameter int VLEN     = 256,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_in,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rs3,
    output logic [VLEN-1:0]     rs1_data,
    output logic [VLEN-1:0]     rs2_data,
    output logic [VLEN-1:0]     rs3_data,
    output logic [VLEN-1:0]     v0_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [4:0]          wr_rd,
    input  logic [1:0]          wr_lmul,
    input  logic [2:0]          wr_sew,
    input  logic [DATA_LEN-1:0] wr_vl,
    input  logic [DATA_LEN-1:0] wr_vstart,
    input  logic                wr_vm,
    input  logic                wr_vta,
    input  logic                wr_vma,
    input  logic [VLEN-1:0]     wr_mask,
    output logic [2:0]          beat_idx,
    input  logic [VLEN-1:0]     beat_data,
    output logic [1:0]          rf_status
);

    logic [VLEN-1:0]     regs_q [32];
    logic [VLEN-1:0]     regs_d [32];
    rf_state_e           state_q, state_d;
    logic [2:0]          beat_q, beat_d;
    logic [4:0]          rd_q, rd_d;
    logic [1:0]          lmul_q, lmul_d;
    logic [1:0]          sew_q, sew_d;
    logic [DATA_LEN-1:0] vl_q, vl_d;
    logic [DATA_LEN-1:0] vstart_q, vstart_d;
    logic                vm_q, vm_d;
    logic                vta_q, vta_d;
    logic                vma_q, vma_d;
    logic [VLEN-1:0]     mask_q, mask_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [4:0]          rs2_q, rs2_d;
    logic [4:0]          rs3_q, rs3_d;

    logic [4:0]          wr_idx;
    logic [2:0]          last_beat;
    logic [VLEN-1:0]     merged_data;

    // rd is aligned and beat < 2^lmul, so this never wraps past v31.
    assign wr_idx    = rd_q + {2'b00, beat_q};
    assign last_beat = 3'((4'd1 << lmul_q) - 4'd1);

    vrf_element_merge #(
        .VLEN     (VLEN),
        .DATA_LEN (DATA_LEN)
    ) u_merge (
        .old_data  (regs_q[wr_idx]),
        .beat_data (beat_data),
        .mask      (mask_q),
        .vstart    (vstart_q),
        .vl        (vl_q),
        .beat      (beat_q),
        .sew       (sew_q),
        .vm        (vm_q),
        .vta       (vta_q),
        .vma       (vma_q),
        .merged    (merged_data)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rd_d     = rd_q;
        lmul_d   = lmul_q;
        sew_d    = sew_q;
        vl_d     = vl_q;
        vstart_d = vstart_q;
        vm_d     = vm_q;
        vta_d    = vta_q;
        vma_d    = vma_q;
        mask_d   = mask_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rs3_d    = rs3_q;
        regs_d   = regs_q;

        if (rdy_in) begin
            rs1_d = rs1;
            rs2_d = rs2;
            rs3_d = rs3;
            case (state_q)
                ST_IDLE: begin
                    if (wr_valid) begin
                        rd_d     = wr_rd;
                        lmul_d   = wr_lmul;
                        sew_d    = wr_sew[1:0];
                        vl_d     = wr_vl;
                        vstart_d = wr_vstart;
                        vm_d     = wr_vm;
                        vta_d    = wr_vta;
                        vma_d    = wr_vma;
                        mask_d   = wr_mask;
                        beat_d   = 3'd0;
                        if (!rd_aligned(wr_rd, wr_lmul) || !sew_legal(wr_sew)) begin
                            state_d = ST_ERR;
                        end else if (wr_vstart >= wr_vl) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    regs_d[wr_idx] = merged_data;
                    if (beat_q == last_beat) begin
                        state_d = ST_DONE;
                        beat_d  = 3'd0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= 3'd0;
            rd_q     <= 5'd0;
            lmul_q   <= 2'd0;
            sew_q    <= 2'd0;
            vl_q     <= '0;
            vstart_q <= '0;
            vm_q     <= 1'b0;
            vta_q    <= 1'b0;
            vma_q    <= 1'b0;
            mask_q   <= '0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rs3_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rd_q     <= rd_d;
            lmul_q   <= lmul_d;
            sew_q    <= sew_d;
            vl_q     <= vl_d;
            vstart_q <= vstart_d;
            vm_q     <= vm_d;
            vta_q    <= vta_d;
            vma_q    <= vma_d;
            mask_q   <= mask_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rs3_q    <= rs3_d;
        end
    end

    assign rs1_data = regs_q[rs1_q];
    assign rs2_data = regs_q[rs2_q];
    assign rs3_data = regs_q[rs3_q];
    assign v0_data  = regs_q[0];
    assign wr_ready = (state_q == ST_IDLE);
    assign beat_idx = beat_q;

    always_comb begin
        rf_status = RF_NOP;
        case (state_q)
            ST_WRITE: rf_status = RF_BUSY;
            ST_DONE:  rf_status = RF_FINISHED;
            ST_ERR:   rf_status = RF_ERROR;
            default:  rf_status = RF_NOP;
        endcase
    end

endmodule

// File: tb/tb_vector_group_register_file.sv
// Directed bench for the grouped vector register file: grouping, masking,
// tail/vstart handling, error/skip paths, stalls and mid-group reset.
module tb_vector_group_register_file;
    import vector_group_register_file_pkg::*;

    localparam int VLEN     = 256;
    localparam int DATA_LEN = 32;

    logic                clk;
    logic                rst;
    logic                rdy_in;
    logic [4:0]          rs1, rs2, rs3;
    logic [VLEN-1:0]     rs1_data, rs2_data, rs3_data, v0_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [4:0]          wr_rd;
    logic [1:0]          wr_lmul;
    logic [2:0]          wr_sew;
    logic [DATA_LEN-1:0] wr_vl, wr_vstart;
    logic                wr_vm, wr_vta, wr_vma;
    logic [VLEN-1:0]     wr_mask;
    logic [2:0]          beat_idx;
    logic [VLEN-1:0]     beat_data;
    logic [1:0]          rf_status;

    int n_cmp = 0;
    int n_mis = 0;

    vector_group_register_file #(.VLEN(VLEN), .DATA_LEN(DATA_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy_in    (rdy_in),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs3_data  (rs3_data),
        .v0_data   (v0_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_rd     (wr_rd),
        .wr_lmul   (wr_lmul),
        .wr_sew    (wr_sew),
        .wr_vl     (wr_vl),
        .wr_vstart (wr_vstart),
        .wr_vm     (wr_vm),
        .wr_vta    (wr_vta),
        .wr_vma    (wr_vma),
        .wr_mask   (wr_mask),
        .beat_idx  (beat_idx),
        .beat_data (beat_data),
        .rf_status (rf_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [VLEN-1:0] exp);
        rs1 = idx;
        tick();
        chk(tag, rs1_data, exp);
    endtask

    task automatic submit(input logic [4:0] rd, input logic [1:0] lmul, input logic [2:0] sew,
                          input logic [31:0] vl, input logic [31:0] vstart, input logic vm,
                          input logic vta, input logic vma, input logic [VLEN-1:0] mask);
        wr_rd = rd; wr_lmul = lmul; wr_sew = sew; wr_vl = vl; wr_vstart = vstart;
        wr_vm = vm; wr_vta = vta; wr_vma = vma; wr_mask = mask;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // Full group write; beat b carries every byte equal to fill+b.
    task automatic do_write(input logic [4:0] rd, input logic [1:0] lmul, input logic [2:0] sew,
                            input logic [31:0] vl, input logic [31:0] vstart, input logic vm,
                            input logic vta, input logic vma, input logic [VLEN-1:0] mask,
                            input logic [7:0] fill);
        int nb;
        nb = 1 << lmul;
        submit(rd, lmul, sew, vl, vstart, vm, vta, vma, mask);
        for (int b = 0; b < nb; b++) begin
            beat_data = {(VLEN/8){fill + 8'(b)}};
            chk("beat_idx", VLEN'(beat_idx), VLEN'(b));
            chk("busy", VLEN'(rf_status), VLEN'(RF_BUSY));
            tick();
        end
        chk("finished", VLEN'(rf_status), VLEN'(RF_FINISHED));
        tick();
        chk("idle_ready", VLEN'(wr_ready), VLEN'(1));
        $display("write rd=%0d lmul=%0d sew=%0d vl=%0d vstart=%0d vm=%0d vta=%0d vma=%0d fill=%02h",
                 rd, lmul, sew, vl, vstart, vm, vta, vma, fill);
    endtask

    logic [VLEN-1:0] exp_v;
    logic [VLEN-1:0] data1;
    logic [VLEN-1:0] masked_v;

    initial begin
        rst = 1'b1; rdy_in = 1'b1; rs1 = '0; rs2 = '0; rs3 = '0;
        wr_valid = 1'b0; wr_rd = '0; wr_lmul = '0; wr_sew = '0; wr_vl = '0; wr_vstart = '0;
        wr_vm = 1'b0; wr_vta = 1'b0; wr_vma = 1'b0; wr_mask = '0; beat_data = '0;

        // Reset state
        tick();
        chk("rst_status", VLEN'(rf_status), VLEN'(RF_NOP));
        chk("rst_ready", VLEN'(wr_ready), VLEN'(1));
        chk("rst_beat", VLEN'(beat_idx), '0);
        chk("rst_rs1", rs1_data, '0);
        chk("rst_v0", v0_data, '0);
        rst = 1'b0;
        tick();

        // Unmasked SEW=32 single register, FINISHED two edges after request
        for (int w = 0; w < 8; w++) data1[w*32 +: 32] = 32'(w + 1);
        beat_data = data1;
        submit(5'd4, 2'd0, FOUR_BYTE, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        chk("t1_busy", VLEN'(rf_status), VLEN'(RF_BUSY));
        chk("t1_ready_low", VLEN'(wr_ready), VLEN'(0));
        tick();
        chk("t1_finished", VLEN'(rf_status), VLEN'(RF_FINISHED));
        tick();
        chk("t1_nop", VLEN'(rf_status), VLEN'(RF_NOP));
        $display("write rd=4 lmul=0 sew=2 vl=8 word pattern");
        chk_reg("t1_v4", 5'd4, data1);

        // lmul=2, SEW=8, vl=70, tail agnostic
        do_write(5'd8, 2'd2, ONE_BYTE, 32'd70, 32'd0, 1'b1, 1'b1, 1'b0, '0, 8'hA0);
        chk_reg("t2_v8", 5'd8, {(VLEN/8){8'hA0}});
        chk_reg("t2_v9", 5'd9, {(VLEN/8){8'hA1}});
        exp_v = {VLEN{1'b1}};
        exp_v[47:0] = {6{8'hA2}};
        chk_reg("t2_v10", 5'd10, exp_v);
        chk_reg("t2_v11", 5'd11, {VLEN{1'b1}});

        // Masked SEW=16, mask=0x55, first undisturbed then agnostic
        do_write(5'd12, 2'd0, TWO_BYTE, 32'd16, 32'd0, 1'b1, 1'b0, 1'b0, '0, 8'h11);
        chk_reg("t3_prefill", 5'd12, {(VLEN/8){8'h11}});
        do_write(5'd12, 2'd0, TWO_BYTE, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, VLEN'(8'h55), 8'h22);
        exp_v = {(VLEN/16){16'h1111}};
        for (int e = 0; e < 8; e += 2) exp_v[e*16 +: 16] = 16'h2222;
        chk_reg("t3_vma0", 5'd12, exp_v);
        do_write(5'd12, 2'd0, TWO_BYTE, 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, VLEN'(8'h55), 8'h33);
        masked_v = {(VLEN/16){16'h1111}};
        for (int e = 0; e < 8; e++) masked_v[e*16 +: 16] = (e % 2 == 0) ? 16'h3333 : 16'hFFFF;
        chk_reg("t3_vma1", 5'd12, masked_v);

        // Misaligned group base
        beat_data = {(VLEN/8){8'h5A}};
        submit(5'd3, 2'd1, FOUR_BYTE, 32'd8, 32'd0, 1'b1, 1'b1, 1'b1, '0);
        chk("t4_error", VLEN'(rf_status), VLEN'(RF_ERROR));
        tick();
        chk("t4_nop", VLEN'(rf_status), VLEN'(RF_NOP));
        chk("t4_ready", VLEN'(wr_ready), VLEN'(1));
        $display("write rd=3 lmul=1 rejected");
        chk_reg("t4_v2", 5'd2, '0);
        chk_reg("t4_v3", 5'd3, '0);

        // Illegal element width
        submit(5'd4, 2'd0, 3'd5, 32'd8, 32'd0, 1'b1, 1'b1, 1'b1, '0);
        chk("t4_sew_error", VLEN'(rf_status), VLEN'(RF_ERROR));
        tick();
        $display("write rd=4 sew=5 rejected");
        chk_reg("t4_v4_kept", 5'd4, data1);

        // Skipped write: vstart == vl, tail must stay even with vta=1
        submit(5'd12, 2'd0, TWO_BYTE, 32'd5, 32'd5, 1'b1, 1'b1, 1'b1, '0);
        chk("t5_skip_fin", VLEN'(rf_status), VLEN'(RF_FINISHED));
        tick();
        chk("t5_skip_nop", VLEN'(rf_status), VLEN'(RF_NOP));
        $display("write rd=12 vstart=5 vl=5 skipped");
        chk_reg("t5_v12_kept", 5'd12, masked_v);

        // vstart > 0 keeps the head elements
        do_write(5'd20, 2'd0, ONE_BYTE, 32'd10, 32'd4, 1'b1, 1'b0, 1'b0, '0, 8'h99);
        exp_v = '0;
        exp_v[79:32] = {6{8'h99}};
        chk_reg("t6_vstart", 5'd20, exp_v);

        // v0 port and the other two read ports
        do_write(5'd0, 2'd0, EIGHT_BYTE, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, '0, 8'h77);
        chk("t7_v0", v0_data, {(VLEN/8){8'h77}});
        rs2 = 5'd8; rs3 = 5'd9;
        tick();
        chk("t7_rs2", rs2_data, {(VLEN/8){8'hA0}});
        chk("t7_rs3", rs3_data, {(VLEN/8){8'hA1}});

        // rdy_in low for three cycles in the middle of a two-member group
        submit(5'd16, 2'd1, FOUR_BYTE, 32'd16, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        beat_data = {(VLEN/8){8'h40}};
        chk("t8_beat0", VLEN'(beat_idx), '0);
        tick();
        beat_data = {(VLEN/8){8'h41}};
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t8_stall_beat", VLEN'(beat_idx), VLEN'(1));
            chk("t8_stall_busy", VLEN'(rf_status), VLEN'(RF_BUSY));
        end
        rdy_in = 1'b1;
        tick();
        chk("t8_finished", VLEN'(rf_status), VLEN'(RF_FINISHED));
        tick();
        $display("write rd=16 lmul=1 with 3-cycle stall");
        chk_reg("t8_v16", 5'd16, {(VLEN/8){8'h40}});
        chk_reg("t8_v17", 5'd17, {(VLEN/8){8'h41}});

        // Reset during the second beat of an lmul=3 group
        submit(5'd24, 2'd3, ONE_BYTE, 32'd256, 32'd0, 1'b1, 1'b0, 1'b0, '0);
        beat_data = {(VLEN/8){8'h50}};
        tick();
        chk("t9_beat1", VLEN'(beat_idx), VLEN'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t9_status", VLEN'(rf_status), VLEN'(RF_NOP));
        chk("t9_ready", VLEN'(wr_ready), VLEN'(1));
        chk("t9_beat", VLEN'(beat_idx), '0);
        $display("write rd=24 lmul=3 abandoned by reset");
        chk_reg("t9_v24", 5'd24, '0);
        chk_reg("t9_v8", 5'd8, '0);
        chk("t9_v0", v0_data, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
